// File: rtl/wb_timer_pkg.sv
// Shared widths, register offsets and reset constants for the Wishbone machine timer.
package wb_timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 64;
  localparam int unsigned OFF_W  = 3;

  localparam logic [OFF_W-1:0] REG_MTIME_LO    = 3'd0;
  localparam logic [OFF_W-1:0] REG_MTIME_HI    = 3'd1;
  localparam logic [OFF_W-1:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [OFF_W-1:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [OFF_W-1:0] REG_PRESCALE    = 3'd4;

  localparam logic [TIME_W-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Decoded view of one bus request as seen by the register file.
  typedef struct packed {
    logic              we;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider: pulses tick once every (prescale + 1) clocks.
module timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] prescale,
  input  logic              clr,
  output logic              tick
);

  logic [DATA_W-1:0] cnt;

  assign tick = (cnt == prescale);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DATA_W'(1);
    end
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone B4 classic slave: 64-bit mtime/mtimecmp with prescaler, driving the machine timer irq.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter logic [31:0] PRESCALE_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        STB,
  input  logic        CYC,
  input  logic [31:0] ADR,
  input  logic        WE,
  input  logic [31:0] DAT_O,
  output logic [31:0] DAT_I,
  output logic        ACK,
  output logic        irq
);

  wb_req_t           req_pl;
  logic              addr_hit;
  logic              req;
  logic              go;
  logic              wr;
  logic              tick;
  logic              wr_mtime_lo;
  logic              wr_mtime_hi;
  logic              wr_cmp_lo;
  logic              wr_cmp_hi;
  logic              wr_prescale;
  logic              unused_adr;
  logic [DATA_W-1:0] prescale;
  logic [DATA_W-1:0] rdata;
  logic [TIME_W-1:0] mtime;
  logic [TIME_W-1:0] mtimecmp;

  // Word-aligned map; byte lanes are not decoded.
  assign unused_adr = ^ADR[1:0];

  assign req_pl   = '{we: WE, off: ADR[4:2], data: DAT_O};
  assign addr_hit = (ADR[31:5] == BASE_ADDR[31:5]);
  assign req      = CYC & STB & addr_hit;
  assign go       = req & ~ACK;
  assign wr       = go & req_pl.we;

  assign wr_mtime_lo = wr & (req_pl.off == REG_MTIME_LO);
  assign wr_mtime_hi = wr & (req_pl.off == REG_MTIME_HI);
  assign wr_cmp_lo   = wr & (req_pl.off == REG_MTIMECMP_LO);
  assign wr_cmp_hi   = wr & (req_pl.off == REG_MTIMECMP_HI);
  assign wr_prescale = wr & (req_pl.off == REG_PRESCALE);

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .prescale (prescale),
    .clr      (wr_prescale),
    .tick     (tick)
  );

  // Read mux; unmapped offsets inside the window read as zero.
  always_comb begin
    rdata = '0;
    case (req_pl.off)
      REG_MTIME_LO:    rdata = mtime[DATA_W-1:0];
      REG_MTIME_HI:    rdata = mtime[TIME_W-1:DATA_W];
      REG_MTIMECMP_LO: rdata = mtimecmp[DATA_W-1:0];
      REG_MTIMECMP_HI: rdata = mtimecmp[TIME_W-1:DATA_W];
      REG_PRESCALE:    rdata = prescale;
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ACK      <= 1'b0;
      DAT_I    <= '0;
      irq      <= 1'b0;
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      prescale <= PRESCALE_RST;
    end else begin
      ACK   <= go;
      DAT_I <= (go & ~req_pl.we) ? rdata : '0;
      irq   <= (mtime >= mtimecmp);

      // A software write to either half suppresses that cycle's increment entirely.
      if (wr_mtime_lo) begin
        mtime[DATA_W-1:0] <= req_pl.data;
      end else if (wr_mtime_hi) begin
        mtime[TIME_W-1:DATA_W] <= req_pl.data;
      end else if (tick) begin
        mtime <= mtime + TIME_W'(1);
      end

      if (wr_cmp_lo) begin
        mtimecmp[DATA_W-1:0] <= req_pl.data;
      end
      if (wr_cmp_hi) begin
        mtimecmp[TIME_W-1:DATA_W] <= req_pl.data;
      end
      if (wr_prescale) begin
        prescale <= req_pl.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Directed plus randomized bench for wb_timer against a closed-form tick-counting reference model.
module tb_wb_timer;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        STB;
  logic        CYC;
  logic [31:0] ADR;
  logic        WE;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I;
  logic        ACK;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference state: mtime = m_base + ticks elapsed since edge m_ref, ticks = (m_cnt0 + edges) / (prescale + 1).
  longint unsigned m_cyc  = 0;
  longint unsigned m_ref  = 0;
  logic [63:0]     m_base = '0;
  logic [63:0]     m_cnt0 = '0;
  logic [63:0]     m_cmp  = '1;
  logic [31:0]     m_pre  = '0;
  logic [31:0]     m_dat  = '0;
  logic            m_ack  = 1'b0;
  logic            m_irq  = 1'b0;

  wb_timer #(.BASE_ADDR(BASE), .PRESCALE_RST(32'd0)) dut (
    .clk   (clk),
    .rst   (rst),
    .STB   (STB),
    .CYC   (CYC),
    .ADR   (ADR),
    .WE    (WE),
    .DAT_O (DAT_O),
    .DAT_I (DAT_I),
    .ACK   (ACK),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pval();
    return {32'd0, m_pre} + 64'd1;
  endfunction

  function automatic logic [63:0] mt();
    logic [63:0] n;
    n = 64'(m_cyc - m_ref);
    return m_base + (m_cnt0 + n) / pval();
  endfunction

  function automatic logic [63:0] cnt_now();
    logic [63:0] n;
    n = 64'(m_cyc - m_ref);
    return (m_cnt0 + n) % pval();
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off, input logic [63:0] t);
    case (off)
      3'd0:    return t[31:0];
      3'd1:    return t[63:32];
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_edge();
    logic [63:0] pmt;
    logic [63:0] pcnt;
    logic        tk;
    logic        req;
    logic        go;
    logic        irq_n;
    pmt  = mt();
    pcnt = cnt_now();
    tk   = (pcnt == pval() - 64'd1);
    req  = CYC && STB && (ADR[31:5] == BASE[31:5]);
    if (!rst) begin
      m_base = '0;
      m_cnt0 = '0;
      m_pre  = 32'd0;
      m_cmp  = '1;
      m_ack  = 1'b0;
      m_dat  = '0;
      m_irq  = 1'b0;
      m_ref  = m_cyc + 1;
    end else begin
      irq_n = (pmt >= m_cmp);
      go    = req && !m_ack;
      m_dat = (go && !WE) ? model_read(ADR[4:2], pmt) : 32'd0;
      m_ack = go;
      if (go && WE) begin
        case (ADR[4:2])
          3'd0: begin
            m_base = {pmt[63:32], DAT_O};
            m_cnt0 = (pcnt + 64'd1) % pval();
            m_ref  = m_cyc + 1;
          end
          3'd1: begin
            m_base = {DAT_O, pmt[31:0]};
            m_cnt0 = (pcnt + 64'd1) % pval();
            m_ref  = m_cyc + 1;
          end
          3'd2: m_cmp[31:0]  = DAT_O;
          3'd3: m_cmp[63:32] = DAT_O;
          3'd4: begin
            m_base = pmt + (tk ? 64'd1 : 64'd0);
            m_pre  = DAT_O;
            m_cnt0 = '0;
            m_ref  = m_cyc + 1;
          end
          default: ;
        endcase
      end
      m_irq = irq_n;
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    CYC   = c;
    STB   = s;
    WE    = w;
    ADR   = a;
    DAT_O = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ack", {63'd0, ACK}, {63'd0, m_ack});
    chk("dat", {32'd0, DAT_I}, {32'd0, m_dat});
    chk("irq", {63'd0, irq}, {63'd0, m_irq});
  endtask

  task automatic xfer(input logic w, input logic [2:0] off, input logic [31:0] wd,
                      output logic [31:0] rd);
    drive(1'b1, 1'b1, w, BASE | (32'(off) << 2), wd);
    step();
    chk("ack_lat", {63'd0, ACK}, 64'd1);
    rd = DAT_I;
    idle();
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] tmp;
    logic        pat [6];
    int          t10;
    int          tirq;

    rst = 1'b0;
    idle();
    step();
    step();
    chk("rst_ack", {63'd0, ACK}, 64'd0);
    chk("rst_dat", {32'd0, DAT_I}, 64'd0);
    chk("rst_irq", {63'd0, irq}, 64'd0);
    rst = 1'b1;
    step();

    xfer(1'b0, 3'd2, 32'd0, rd);
    chk("cmp_lo_rst", {32'd0, rd}, 64'hFFFF_FFFF);
    xfer(1'b0, 3'd3, 32'd0, rd);
    chk("cmp_hi_rst", {32'd0, rd}, 64'hFFFF_FFFF);
    chk("irq_rst", {63'd0, irq}, 64'd0);

    // Compare match at 10 with prescale 0.
    xfer(1'b1, 3'd0, 32'd0, rd);
    xfer(1'b1, 3'd1, 32'd0, rd);
    xfer(1'b1, 3'd2, 32'd10, rd);
    xfer(1'b1, 3'd3, 32'd0, rd);
    chk("irq_before", {63'd0, irq}, 64'd0);
    t10  = -1;
    tirq = -1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (t10 < 0 && mt() == 64'd10) t10 = k;
      if (irq === 1'b1) begin
        tirq = k;
        break;
      end
    end
    chk("irq_seen", {63'd0, (tirq >= 0)}, 64'd1);
    chk("irq_rise_lat", 64'(tirq - t10), 64'd1);
    drive(1'b1, 1'b1, 1'b1, BASE | 32'h8, 32'd1000);
    step();
    chk("irq_hold", {63'd0, irq}, 64'd1);
    idle();
    step();
    chk("irq_clear", {63'd0, irq}, 64'd0);

    // Prescale 3: one increment per four clocks.
    xfer(1'b1, 3'd4, 32'd3, rd);
    xfer(1'b0, 3'd0, 32'd0, a);
    repeat (38) step();
    xfer(1'b0, 3'd0, 32'd0, b);
    chk("presc_delta", {32'd0, b - a}, 64'd10);
    xfer(1'b0, 3'd4, 32'd0, rd);
    chk("presc_rd", {32'd0, rd}, 64'd3);

    // Carry out of the low word.
    xfer(1'b1, 3'd4, 32'd0, rd);
    xfer(1'b1, 3'd1, 32'd0, rd);
    xfer(1'b1, 3'd0, 32'hFFFF_FFFF, rd);
    xfer(1'b0, 3'd0, 32'd0, rd);
    chk("wrap_lo", {32'd0, rd}, 64'd0);
    xfer(1'b0, 3'd1, 32'd0, rd);
    chk("wrap_hi", {32'd0, rd}, 64'd1);

    // Prescale 1 aligns the mtime_lo write onto a tick edge.
    xfer(1'b1, 3'd4, 32'd1, rd);
    xfer(1'b1, 3'd0, 32'd5, rd);
    xfer(1'b0, 3'd0, 32'd0, rd);
    chk("write_wins", {32'd0, rd}, 64'd5);

    xfer(1'b0, 3'd7, 32'd0, rd);
    chk("unmapped_rd", {32'd0, rd}, 64'd0);
    xfer(1'b1, 3'd7, 32'hDEAD_BEEF, rd);

    // Held request: ACK every other cycle.
    drive(1'b1, 1'b1, 1'b0, BASE, 32'd0);
    for (int k = 0; k < 6; k++) begin
      pat[k] = ACK;
      step();
    end
    for (int k = 0; k < 6; k++) chk($sformatf("held_ack%0d", k), {63'd0, pat[k]}, 64'(k % 2));
    idle();
    step();

    // Reset during a pending write must not commit it.
    drive(1'b1, 1'b1, 1'b1, BASE | 32'h8, 32'h0000_1234);
    rst = 1'b0;
    step();
    chk("rst_mid_ack", {63'd0, ACK}, 64'd0);
    rst = 1'b1;
    idle();
    step();
    xfer(1'b0, 3'd2, 32'd0, rd);
    chk("rst_no_commit", {32'd0, rd}, 64'hFFFF_FFFF);

    drive(1'b0, 1'b1, 1'b0, BASE, 32'd0);
    step();
    chk("cyc_low_ack", {63'd0, ACK}, 64'd0);
    idle();
    step();

    for (int i = 0; i < 250; i++) begin
      int          kind;
      int          hold;
      int          gap;
      logic [2:0]  off;
      logic        w;
      logic [31:0] d;
      logic [31:0] adr;
      kind = int'($urandom_range(0, 9));
      off  = 3'($urandom_range(0, 7));
      w    = 1'($urandom_range(0, 1));
      d    = $urandom;
      tmp  = mt();
      if (off == 3'd4) d = $urandom_range(0, 3);
      if (off == 3'd1) d = $urandom_range(0, 2);
      if (off == 3'd2) d = tmp[31:0] + 32'($urandom_range(0, 30));
      if (off == 3'd3) d = tmp[63:32] + 32'($urandom_range(0, 1));
      adr = (kind == 0) ? (32'h1000_0000 | (32'(off) << 2)) : (BASE | (32'(off) << 2));
      drive((kind == 1) ? 1'b0 : 1'b1, 1'b1, w, adr, d);
      hold = int'($urandom_range(1, 4));
      repeat (hold) step();
      idle();
      gap = int'($urandom_range(0, 2));
      repeat (gap) step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
